// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: register-file geometry and the register-index type.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter: one issue increment and up to two retires per cycle.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic [1:0]       dec,
    output logic [CNT_W-1:0] cnt,
    output logic             nonzero,
    output logic             at_max,
    output logic             underflow
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W+1:0] sum;

    // Two extra bits so the compare against dec (0..2) cannot wrap.
    always_comb begin
        sum       = {2'b00, cnt_q} + {{(CNT_W+1){1'b0}}, inc};
        underflow = ({{CNT_W{1'b0}}, dec} > sum);
        cnt_d     = cnt_q;
        if (underflow) begin
            cnt_d = '0;
        end else begin
            cnt_d = CNT_W'(sum - {{CNT_W{1'b0}}, dec});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign nonzero = |cnt_q;
    assign at_max  = &cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage register scoreboard: stalls sources with in-flight writes.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a source issue in the cycle its last write retires.
module reg_scoreboard
    import riscv_pkg::*;
#(
    parameter int CNT_W   = 2,
    parameter int STALL_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  reg_idx_t            issue_rs1,
    input  reg_idx_t            issue_rs2,
    input  logic                issue_rs1_used,
    input  logic                issue_rs2_used,
    input  reg_idx_t            issue_rd,
    input  logic                issue_rd_we,
    output logic                issue_ready,
    input  logic                wb_valid,
    input  reg_idx_t            wb_rd,
    input  logic                cancel_valid,
    input  reg_idx_t            cancel_rd,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [STALL_W-1:0]  stall_cnt,
    output logic                err
);

    logic [CNT_W-1:0]    cnt_arr [NUM_REGS];
    logic [NUM_REGS-1:0] nonzero_vec;
    logic [NUM_REGS-1:0] at_max_vec;
    logic [NUM_REGS-1:0] underflow_vec;
    logic                accept;
    logic                pend_rs1, pend_rs2;
    logic                hazard_rs1, hazard_rs2, saturation;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic                err_q, err_d;

    // x0 has no counter: it never reports pending, full or underflow.
    assign cnt_arr[0]       = '0;
    assign nonzero_vec[0]   = 1'b0;
    assign at_max_vec[0]    = 1'b0;
    assign underflow_vec[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic       inc;
            logic [1:0] dec;

            assign inc = accept && issue_rd_we && (issue_rd == reg_idx_t'(gi));
            assign dec = {1'b0, wb_valid && (wb_rd == reg_idx_t'(gi))}
                       + {1'b0, cancel_valid && (cancel_rd == reg_idx_t'(gi))};

            sb_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk       (clk),
                .reset     (reset),
                .inc       (inc),
                .dec       (dec),
                .cnt       (cnt_arr[gi]),
                .nonzero   (nonzero_vec[gi]),
                .at_max    (at_max_vec[gi]),
                .underflow (underflow_vec[gi])
            );
        end
    endgenerate

`ifdef SCOREBOARD_WB_BYPASS_EN
    logic [1:0] dec_rs1, dec_rs2;

    // A source is still pending only if more writes are outstanding than retire now.
    always_comb begin
        dec_rs1  = {1'b0, wb_valid && (wb_rd == issue_rs1)}
                 + {1'b0, cancel_valid && (cancel_rd == issue_rs1)};
        dec_rs2  = {1'b0, wb_valid && (wb_rd == issue_rs2)}
                 + {1'b0, cancel_valid && (cancel_rd == issue_rs2)};
        pend_rs1 = ({1'b0, cnt_arr[issue_rs1]} > {{(CNT_W-1){1'b0}}, dec_rs1});
        pend_rs2 = ({1'b0, cnt_arr[issue_rs2]} > {{(CNT_W-1){1'b0}}, dec_rs2});
    end
`else
    always_comb begin
        pend_rs1 = (cnt_arr[issue_rs1] != '0);
        pend_rs2 = (cnt_arr[issue_rs2] != '0);
    end
`endif

    always_comb begin
        hazard_rs1  = issue_rs1_used && (issue_rs1 != '0) && pend_rs1;
        hazard_rs2  = issue_rs2_used && (issue_rs2 != '0) && pend_rs2;
        // Uses the registered count; a retire in the same cycle does not free a slot.
        saturation  = issue_rd_we && (issue_rd != '0) && at_max_vec[issue_rd];
        issue_ready = !reset && !hazard_rs1 && !hazard_rs2 && !saturation;
        accept      = issue_valid && issue_ready;
    end

    always_comb begin
        stall_d = stall_q;
        err_d   = err_q;
        if (issue_valid && !issue_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        if (|underflow_vec) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign busy_vec  = nonzero_vec;
    assign stall_cnt = stall_q;
    assign err       = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios then random traffic against a count model.
module tb_reg_scoreboard;

    localparam int CNT_W   = 2;
    localparam int STALL_W = 16;
    localparam int MAXC    = (1 << CNT_W) - 1;
    localparam int SMAX    = (1 << STALL_W) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_rs1_used, issue_rs2_used, issue_rd_we;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        cancel_valid;
    logic [4:0]  cancel_rd;
    logic [31:0] busy_vec;
    logic [STALL_W-1:0] stall_cnt;
    logic        err;

    int mcnt [32];
    int mstall;
    bit merr;
    int check_cnt = 0;
    int pass_cnt  = 0;

    reg_scoreboard #(
        .CNT_W   (CNT_W),
        .STALL_W (STALL_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_rs1_used (issue_rs1_used),
        .issue_rs2_used (issue_rs2_used),
        .issue_rd       (issue_rd),
        .issue_rd_we    (issue_rd_we),
        .issue_ready    (issue_ready),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .cancel_valid   (cancel_valid),
        .cancel_rd      (cancel_rd),
        .busy_vec       (busy_vec),
        .stall_cnt      (stall_cnt),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    endtask

    function automatic int mdec(input int r);
        return int'(wb_valid && (int'(wb_rd) == r)) + int'(cancel_valid && (int'(cancel_rd) == r));
    endfunction

    function automatic bit pending(input int s);
`ifdef SCOREBOARD_WB_BYPASS_EN
        return (mcnt[s] - mdec(s)) > 0;
`else
        return mcnt[s] > 0;
`endif
    endfunction

    function automatic bit model_ready();
        bit h1, h2, sat;
        if (reset) return 1'b0;
        h1  = issue_rs1_used && (issue_rs1 != 0) && pending(int'(issue_rs1));
        h2  = issue_rs2_used && (issue_rs2 != 0) && pending(int'(issue_rs2));
        sat = issue_rd_we && (issue_rd != 0) && (mcnt[issue_rd] == MAXC);
        return !h1 && !h2 && !sat;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        for (int r = 1; r < 32; r++) b[r] = (mcnt[r] != 0);
        return b;
    endfunction

    task automatic model_update();
        bit rdy = model_ready();
        int n;
        if (reset) begin
            for (int r = 0; r < 32; r++) mcnt[r] = 0;
            mstall = 0;
            merr   = 1'b0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                n = mcnt[r] + int'(issue_valid && rdy && issue_rd_we && (int'(issue_rd) == r)) - mdec(r);
                if (n < 0) begin
                    n    = 0;
                    merr = 1'b1;
                end
                mcnt[r] = n;
            end
            if (issue_valid && !rdy && (mstall < SMAX)) mstall++;
        end
    endtask

    // One clock: check issue_ready mid-cycle, advance the model at the edge, check state after it.
    task automatic step();
        #1;
        chk("issue_ready", {31'b0, issue_ready}, {31'b0, model_ready()});
        @(posedge clk);
        model_update();
        #1;
        chk("busy_vec", busy_vec, model_busy());
        chk("stall_cnt", {16'b0, stall_cnt}, 32'(mstall));
        chk("err", {31'b0, err}, {31'b0, merr});
        $display("t=%0t v=%0b rs1=%0d rs2=%0d rd=%0d we=%0b wb=%0b/%0d cn=%0b/%0d busy=%08h stall=%0d err=%0b",
                 $time, issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_we,
                 wb_valid, wb_rd, cancel_valid, cancel_rd, busy_vec, stall_cnt, err);
    endtask

    task automatic iss(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit we);
        issue_valid    = v;
        issue_rs1      = 5'(r1);
        issue_rs1_used = u1;
        issue_rs2      = 5'(r2);
        issue_rs2_used = u2;
        issue_rd       = 5'(rd);
        issue_rd_we    = we;
    endtask

    task automatic wbk(input bit v, input int r);
        wb_valid = v;
        wb_rd    = 5'(r);
    endtask

    task automatic cnl(input bit v, input int r);
        cancel_valid = v;
        cancel_rd    = 5'(r);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        mstall = 0;
        merr   = 1'b0;
        reset  = 1'b1;
        iss(0, 0, 0, 0, 0, 0, 0);
        wbk(0, 0);
        cnl(0, 0);

        // Reset state and idle release
        step();
        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_ready", {31'b0, issue_ready}, 32'h0);
        step();
        reset = 1'b0;
        step();
        chk("idle_ready", {31'b0, issue_ready}, 32'h1);

        // RAW on x5, retired by writeback
        iss(1, 0, 0, 0, 0, 5, 1);
        step();
        iss(1, 5, 1, 0, 0, 6, 1);
        step();
        wbk(1, 5);
`ifdef SCOREBOARD_WB_BYPASS_EN
        #1;
        chk("raw_wb_ready", {31'b0, issue_ready}, 32'h1);
`else
        #1;
        chk("raw_wb_ready", {31'b0, issue_ready}, 32'h0);
`endif
        step();
        wbk(0, 0);
        step();
`ifdef SCOREBOARD_WB_BYPASS_EN
        chk("raw_stalls", {16'b0, stall_cnt}, 32'd1);
`else
        chk("raw_stalls", {16'b0, stall_cnt}, 32'd2);
`endif
        iss(0, 0, 0, 0, 0, 0, 0);
        wbk(1, 6);
        for (int k = 0; k < 4 && mcnt[6] > 0; k++) step();
        wbk(0, 0);

        // WAW up to saturation on x7
        iss(1, 0, 0, 0, 0, 7, 1);
        for (int k = 0; k < 3; k++) step();
        #1;
        chk("sat_ready", {31'b0, issue_ready}, 32'h0);
        step();
        wbk(1, 7);
        cnl(1, 7);
        #1;
        chk("sat_retire_ready", {31'b0, issue_ready}, 32'h0);
        step();
        wbk(0, 0);
        cnl(0, 0);
        #1;
        chk("sat_lift_ready", {31'b0, issue_ready}, 32'h1);
        step();
        iss(0, 0, 0, 0, 0, 0, 0);
        wbk(1, 7);
        for (int k = 0; k < 4 && mcnt[7] > 0; k++) step();
        wbk(0, 0);

        // x0 is ignored everywhere
        iss(1, 0, 1, 0, 1, 0, 1);
        wbk(1, 0);
        cnl(1, 0);
        step();
        step();
        chk("x0_busy", busy_vec, 32'h0);
        chk("x0_err", {31'b0, err}, 32'h0);
        iss(0, 0, 0, 0, 0, 0, 0);
        wbk(0, 0);
        cnl(0, 0);

        // Underflow on x9 is sticky
        wbk(1, 9);
        step();
        wbk(0, 0);
        chk("uf_err", {31'b0, err}, 32'h1);
        for (int k = 0; k < 3; k++) step();
        chk("uf_err_sticky", {31'b0, err}, 32'h1);

        // Reset discards in-flight writes and the concurrent issue
        iss(1, 0, 0, 0, 0, 3, 1);
        step();
        step();
        reset = 1'b1;
        #1;
        chk("rst_mid_ready", {31'b0, issue_ready}, 32'h0);
        step();
        chk("rst_mid_busy", busy_vec, 32'h0);
        reset = 1'b0;
        iss(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("post_rst_busy", busy_vec, 32'h0);
        chk("post_rst_err", {31'b0, err}, 32'h0);

        // Random traffic on a small register window to force collisions
        for (int n = 0; n < 400; n++) begin
            int r;
            reset = ($urandom_range(0, 99) == 0);
            iss($urandom_range(0, 3) != 0,
                $urandom_range(0, 7), $urandom_range(0, 1) != 0,
                $urandom_range(0, 7), $urandom_range(0, 1) != 0,
                $urandom_range(0, 7), $urandom_range(0, 3) != 0);
            r = $urandom_range(1, 7);
            wbk((mcnt[r] > 0) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 19) == 0), r);
            r = $urandom_range(0, 7);
            cnl((mcnt[r] > 0) && ($urandom_range(0, 3) == 0), r);
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
